// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: issues the data-memory request/ack handshake,
// stalls upstream while memory is busy, extends load data and registers the WB bundle.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_mem,
    input  logic [4:0]  rd_addr_mem,
    input  logic        wb_en_mem,
    input  logic        float_wb_en_mem,
    input  logic [2:0]  is_load_mem,
    input  logic        is_store_mem,
    input  logic [31:0] st_wdata_mem,
    input  logic [31:0] st_bweb_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_bweb,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_mem,
    output logic        dm_err,
    output logic [4:0]  rd_addr_wb,
    output logic        wb_en_wb,
    output logic        float_wb_en_wb,
    output logic [31:0] wb_data_wb
);

    localparam int unsigned CNT_NEED = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        is_st;
    logic        is_ld;
    logic        mem_op;
    logic        timeout;
    logic        abort;
    logic        req;
    logic        stall;
    logic [31:0] sh;
    logic [31:0] ld_data;

    // Request/stall decode; store wins over a simultaneous load, 3'b111 is no load.
    always_comb begin
        is_st   = is_store_mem;
        is_ld   = !is_store_mem && (is_load_mem != 3'b000) && (is_load_mem != 3'b111);
        mem_op  = is_st || is_ld;
        timeout = (state == WAIT) && (cnt == CNT_W'(TIMEOUT_CYC));
        req     = !rst && mem_op && !timeout;
        stall   = req && !dm_ack;
        abort   = !rst && timeout;
    end

    // Load alignment: shifted-out lanes fill with zeros from the top.
    always_comb begin
        sh = dm_rdata >> {alu_out_mem[1:0], 3'b000};
        case (is_load_mem)
            3'b010:  ld_data = {{16{sh[15]}}, sh[15:0]};
            3'b011:  ld_data = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld_data = {16'h0000, sh[15:0]};
            3'b101:  ld_data = {24'h00_0000, sh[7:0]};
            default: ld_data = sh;
        endcase
    end

    assign dm_req    = req;
    assign dm_we     = req && is_st;
    assign dm_addr   = {alu_out_mem[31:2], 2'b00};
    assign dm_wdata  = is_st ? st_wdata_mem : 32'h0000_0000;
    assign dm_bweb   = is_st ? st_bweb_mem : 32'hffff_ffff;
    assign stall_mem = stall;

    // FSM, timeout counter, sticky error and WB register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            dm_err         <= 1'b0;
            rd_addr_wb     <= 5'd0;
            wb_en_wb       <= 1'b0;
            float_wb_en_wb <= 1'b0;
            wb_data_wb     <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (stall) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state  <= IDLE;
                        dm_err <= 1'b1;
                    end else if (!stall) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (stall || abort) begin
                wb_en_wb       <= 1'b0;
                float_wb_en_wb <= 1'b0;
            end else begin
                rd_addr_wb     <= rd_addr_mem;
                wb_en_wb       <= wb_en_mem;
                float_wb_en_wb <= float_wb_en_mem;
                wb_data_wb     <= is_ld ? ld_data : alu_out_mem;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: randomized ops against a byte-level memory model,
// with a monitor popping expected WB bundles whenever the DUT writes back.
module tb_mem_wb_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_mem;
    logic [4:0]  rd_addr_mem;
    logic        wb_en_mem;
    logic        float_wb_en_mem;
    logic [2:0]  is_load_mem;
    logic        is_store_mem;
    logic [31:0] st_wdata_mem;
    logic [31:0] st_bweb_mem;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_bweb;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall_mem;
    logic        dm_err;
    logic [4:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic        float_wb_en_wb;
    logic [31:0] wb_data_wb;

    mem_wb_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .alu_out_mem(alu_out_mem), .rd_addr_mem(rd_addr_mem),
        .wb_en_mem(wb_en_mem), .float_wb_en_mem(float_wb_en_mem),
        .is_load_mem(is_load_mem), .is_store_mem(is_store_mem),
        .st_wdata_mem(st_wdata_mem), .st_bweb_mem(st_bweb_mem),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_bweb(dm_bweb),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_mem(stall_mem), .dm_err(dm_err),
        .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb),
        .float_wb_en_wb(float_wb_en_wb), .wb_data_wb(wb_data_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic        fwen;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem[16];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load result built from the individual bytes at and above the offset.
    function automatic logic [31:0] load_model(input logic [2:0] ld, input logic [31:0] word,
                                               input logic [1:0] o);
        logic [7:0] b[4];
        for (int i = 0; i < 4; i++) begin
            int k;
            k = int'(o) + i;
            b[i] = (k < 4) ? word[8*k +: 8] : 8'h00;
        end
        case (ld)
            3'd2:    return 32'($signed({b[1], b[0]}));
            3'd3:    return 32'($signed(b[0]));
            3'd4:    return {16'h0000, b[1], b[0]};
            3'd5:    return {24'h00_0000, b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    task automatic drive_nop();
        is_load_mem     = 3'd0;
        is_store_mem    = 1'b0;
        wb_en_mem       = 1'b0;
        float_wb_en_mem = 1'b0;
        dm_ack          = 1'b0;
    endtask

    // Issue one op just after a falling edge; delay<0 means memory never acks.
    task automatic run_op(input logic [2:0] ld, input bit st, input logic [31:0] addr,
                          input logic [4:0] rd, input bit wen, input bit fwen,
                          input logic [31:0] wdata, input logic [31:0] bweb, input int delay);
        bit          memop;
        bit          is_l;
        bit          done;
        int          stalls;
        int          exp_stalls;
        logic [31:0] exp_data;
        exp_t        e;
        alu_out_mem     = addr;
        rd_addr_mem     = rd;
        wb_en_mem       = wen;
        float_wb_en_mem = fwen;
        is_load_mem     = ld;
        is_store_mem    = st;
        st_wdata_mem    = wdata;
        st_bweb_mem     = bweb;
        memop    = st || (ld != 3'd0 && ld != 3'd7);
        is_l     = memop && !st;
        exp_data = is_l ? load_model(ld, mem[addr[5:2]], addr[1:0]) : addr;
        stalls   = 0;
        done     = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (memop) dm_ack = (delay >= 0) && (stalls == delay);
            else       dm_ack = 1'($urandom_range(0, 1));
            dm_rdata = (memop && dm_ack) ? mem[addr[5:2]] : $urandom;
            #1;
            if (memop && dm_req) chk("dm_addr", dm_addr, {addr[31:2], 2'b00});
            if (!stall_mem) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        chk("op_done", 32'(done), 32'd1);
        exp_stalls = !memop ? 0 : (delay >= 0 ? delay : int'(TO) + 1);
        chk("stall_cycles", stalls, exp_stalls);
        if (delay < 0) chk("dm_req_abort", 32'(dm_req), 32'd0);
        if (!memop) chk("dm_req_idle", 32'(dm_req), 32'd0);
        if (st && delay >= 0) begin
            chk("dm_we_st", 32'(dm_we), 32'd1);
            chk("dm_bweb_st", dm_bweb, bweb);
            chk("dm_wdata_st", dm_wdata, wdata);
            mem[addr[5:2]] = (mem[addr[5:2]] & bweb) | (wdata & ~bweb);
        end
        if (is_l && delay >= 0) begin
            chk("dm_we_ld", 32'(dm_we), 32'd0);
            chk("dm_bweb_ld", dm_bweb, 32'hffff_ffff);
        end
        if ((wen || fwen) && (delay >= 0 || !memop)) begin
            e.rd = rd; e.wen = wen; e.fwen = fwen; e.data = exp_data;
            q.push_back(e);
        end
        @(negedge clk);
        drive_nop();
        if (delay < 0) chk("dm_err_set", 32'(dm_err), 32'd1);
    endtask

    // Monitor: every writeback the DUT presents must match the oldest expected bundle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (wb_en_wb || float_wb_en_wb)) begin
                if (q.size() == 0) begin
                    chk("unexpected_wb", 32'(wb_en_wb | float_wb_en_wb), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("wb_rd", 32'(rd_addr_wb), 32'(e.rd));
                    chk("wb_en", 32'(wb_en_wb), 32'(e.wen));
                    chk("wb_fen", 32'(float_wb_en_wb), 32'(e.fwen));
                    chk("wb_data", wb_data_wb, e.data);
                end
            end
        end
    end

    initial begin
        logic [2:0] ld;
        bit         st;
        rst = 1'b1;
        drive_nop();
        alu_out_mem  = 32'h0;
        rd_addr_mem  = 5'd0;
        st_wdata_mem = 32'h0;
        st_bweb_mem  = 32'hffff_ffff;
        dm_rdata     = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        is_store_mem = 1'b1;
        #12;
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_stall", 32'(stall_mem), 32'd0);
        chk("rst_wb_en", 32'(wb_en_wb), 32'd0);
        chk("rst_fwb_en", 32'(float_wb_en_wb), 32'd0);
        chk("rst_rd", 32'(rd_addr_wb), 32'd0);
        chk("rst_wb_data", wb_data_wb, 32'd0);
        chk("rst_dm_err", 32'(dm_err), 32'd0);
        @(negedge clk);
        drive_nop();
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(3'd0, 1'b0, 32'h1234_5678, 5'd5, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 0);
        mem[0] = 32'h80AA_BBCC;
        run_op(3'd3, 1'b0, 32'h0000_0003, 5'd6, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 0);
        run_op(3'd5, 1'b0, 32'h0000_0003, 5'd7, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 0);
        run_op(3'd2, 1'b0, 32'h0000_0002, 5'd8, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 0);
        run_op(3'd1, 1'b0, 32'h0000_0010, 5'd9, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 3);
        run_op(3'd0, 1'b1, 32'h0000_0020, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 0);
        run_op(3'd1, 1'b0, 32'h0000_0020, 5'd10, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 0);
        run_op(3'd6, 1'b0, 32'h0000_0021, 5'd11, 1'b0, 1'b1, 32'h0, 32'hffff_ffff, 1);

        // Randomized mix, including load+store overlap and reserved load type
        for (int n = 0; n < 300; n++) begin
            ld = 3'($urandom_range(0, 7));
            st = ($urandom_range(0, 4) == 0);
            if (st || (ld != 3'd0 && ld != 3'd7)) begin
                run_op(ld, st, 32'($urandom_range(0, 63)), 5'($urandom), st ? 1'b0 : 1'($urandom),
                       (!st && ld == 3'd6) ? 1'($urandom) : 1'b0, $urandom, $urandom,
                       $urandom_range(0, int'(TO)));
            end else begin
                run_op(ld, 1'b0, $urandom, 5'($urandom), 1'($urandom), 1'b0,
                       32'h0, 32'hffff_ffff, 0);
            end
        end
        chk("no_err_random", 32'(dm_err), 32'd0);

        // Timeout abort, then normal pass-through
        run_op(3'd1, 1'b0, 32'h0000_0008, 5'd12, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, -1);
        run_op(3'd0, 1'b0, 32'hCAFE_0001, 5'd13, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 0);
        chk("dm_err_sticky", 32'(dm_err), 32'd1);
        @(negedge clk);

        // Reset in the middle of a WAIT
        alu_out_mem = 32'h0000_0004;
        rd_addr_mem = 5'd14;
        wb_en_mem   = 1'b1;
        is_load_mem = 3'd1;
        dm_ack      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("wait_stall", 32'(stall_mem), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(dm_req), 32'd0);
        chk("mid_rst_stall", 32'(stall_mem), 32'd0);
        chk("mid_rst_err", 32'(dm_err), 32'd0);
        chk("mid_rst_wb_en", 32'(wb_en_wb), 32'd0);
        chk("mid_rst_rd", 32'(rd_addr_wb), 32'd0);
        chk("mid_rst_data", wb_data_wb, 32'd0);
        @(negedge clk);
        drive_nop();
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd0, 1'b0, 32'h0BAD_F00D, 5'd15, 1'b1, 1'b0, 32'h0, 32'hffff_ffff, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
